mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer that sits directly upstream and downstream of the 8:1 4-bit multiplexer. It drives the mux select `S` and samples the mux output `Y`. On `start`, it walks through the enabled channels in ascending order and holds each select value for a programmable settle window. It captures each selected value into an 8-entry register bank and reports the per-pass maximum and the channel that produced it.

## Interface
Parameters:
- `WIDTH`, default 4: data width; matches the mux `Y`.
- `SETTLE`, default 1, legal range 0–15: extra cycles `sel` is held before capture.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a scan; sampled only in IDLE.
- `abort`, input, 1: end the scan immediately.
- `continuous`, input, 1: restart automatically after each pass; latched at start.
- `mask`, input, 8: channel enable, one bit per channel; latched at start.
- `sel`, output, 3: registered; drives the mux `S`.
- `y_in`, input, WIDTH: from the mux `Y`.
- `rd_addr`, input, 3: bank read address.
- `rd_data`, output, WIDTH: combinational `bank[rd_addr]`.
- `valid`, output, 8: bit n is set once channel n has been captured since the last start.
- `busy`, output, 1: high while scanning.
- `done`, output, 1: one-cycle pulse at the end of each pass.
- `max_val`, output, WIDTH: largest value captured in the last completed pass.
- `max_ch`, output, 3: channel that produced `max_val`.

## Operation
- FSM states:
  - IDLE.
  - SCAN: dwell counter `cnt`, 0..SETTLE.
- IDLE, `start`=1, latched mask ≠ 0:
  - `sel` ← lowest enabled channel; `cnt` ← 0; `busy` ← 1.
  - `valid` ← 0; running max cleared.
  - Go to SCAN.
- IDLE, `start`=1, mask = 0:
  - `valid` ← 0; `done` pulses.
  - `max_val`/`max_ch` ← 0/0; stay in IDLE.
- SCAN, `cnt` < SETTLE: `cnt` increments.
- SCAN, `cnt` = SETTLE (capture edge):
  - `bank[sel]` ← `y_in`; `valid[sel]` ← 1.
  - Running max is updated if this is the first capture of the pass or if `y_in` > running max (strict). On ties, the lowest channel wins.
  - `cnt` ← 0.
  - If a higher enabled channel exists, `sel` ← next enabled channel and stay in SCAN.
  - Otherwise the pass ends:
    - `max_val`/`max_ch` ← running result.
    - `done` ← 1 for one cycle.
    - If latched `continuous`=1: `sel` ← lowest enabled channel, running max cleared, stay in SCAN. `valid` is not cleared.
    - Else: go to IDLE with `busy` ← 0.
- `start` while in SCAN is ignored.
- Changes to `mask` or `continuous` mid-scan are ignored.
- `abort`=1 in SCAN:
  - Go to IDLE on the next edge with `busy` ← 0.
  - No capture occurs on that edge, even if `cnt` = SETTLE.
  - No `done` pulse.
  - Bank, `valid`, `max_val` and `max_ch` keep their values; `sel` holds.
  - `abort` has priority over a capture on the same edge.
- `abort` in IDLE has no effect.
- Reset values (asynchronous): `sel`=0, `busy`=0, `done`=0, `valid`=0, `max_val`=0, `max_ch`=0, `cnt`=0, all bank entries=0 (so `rd_data`=0), state=IDLE.
- Reset asserted mid-scan returns all of the above to their reset values immediately. No `done` pulse.

## Timing
- Per enabled channel, `sel` is stable for exactly SETTLE+1 cycles.
- `y_in` is sampled just before the capture edge. The mux is combinational, so it has at least SETTLE+1 cycles to settle.
- `start` seen at edge E0:
  - `sel` and `busy` update at E0.
  - The k-th capture (k = 1..N enabled channels) happens at E0 + k·(SETTLE+1).
- Last capture edge EL:
  - `done`=1 from EL to EL+1.
  - `busy` falls at EL in one-shot mode.
  - `max_val`/`max_ch` update at EL.
- Full 8-channel pass with SETTLE=1: 16 cycles.
- Back-to-back: `start` is accepted at EL+1 at the earliest (in IDLE).
- `rd_data` has zero latency. A read at the capture address returns the new value starting from the capture edge.

## Test plan
- Mux inputs i0..i7 = 4,8,1,15,3,7,0,14; mask=0xFF; SETTLE=1; one start pulse:
  - `sel` steps 0→7, each held 2 cycles.
  - bank = 4,8,1,15,3,7,0,14.
  - `valid`=0xFF.
  - `max_val`=15, `max_ch`=3.
  - `done` pulses 16 cycles after start; `busy` then falls.
- Same inputs, mask=0xA0:
  - Only channels 5 and 7 are scanned; `valid`=0xA0.
  - `max_val`=14, `max_ch`=7.
  - `done` at start+4.
- Tie: i2=i6=9, all other inputs 0, mask=0xFF: `max_val`=9, `max_ch`=2.
- `continuous`=1, mask=0x03, SETTLE=0:
  - `sel` alternates 0,1,0,1.
  - `done` pulses every 2 cycles.
  - Change i1 mid-run; `max_val` tracks it from the next pass.
  - `busy` stays 1 until `abort`.
- `abort` asserted on the capture edge of channel 4:
  - bank[4] is unchanged and `valid[4]`=0.
  - `busy`=0; no `done` pulse.
  - A new `start` is then accepted.
- `rst_n` low mid-scan:
  - All outputs go to their reset values immediately, asynchronously.
  - `rd_data`=0 for every address.
  - mask=0 with start → `done` pulse, `valid`=0, `busy` stays 0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps the select through enabled channels,
// captures each sample into a register bank and reports the per-pass maximum.
module mux_scan_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [7:0]       mask,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] y_in,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [2:0]       max_ch
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e           state_q;
  logic [2:0]       sel_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       valid_q;
  logic [WIDTH-1:0] max_val_q;
  logic [2:0]       max_ch_q;
  logic [7:0]       mask_q;
  logic             cont_q;
  logic [WIDTH-1:0] run_max_q;
  logic [2:0]       run_ch_q;
  logic             run_empty_q;
  logic [WIDTH-1:0] bank_q [8];

  logic [2:0]       idx;
  logic [2:0]       first_in;
  logic [2:0]       first_q;
  logic [2:0]       next_ch;
  logic             has_next;
  logic             take;
  logic [WIDTH-1:0] cap_max;
  logic [2:0]       cap_ch;

  // Descending walk so the last hit is the lowest qualifying channel.
  always_comb begin
    idx      = '0;
    first_in = '0;
    first_q  = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(7 - i);
      if (mask[idx])   first_in = idx;
      if (mask_q[idx]) first_q  = idx;
      if (mask_q[idx] && (idx > sel_q)) begin
        next_ch  = idx;
        has_next = 1'b1;
      end
    end
  end

  // Strict compare in ascending order keeps the lowest channel on ties.
  always_comb begin
    take    = run_empty_q || (y_in > run_max_q);
    cap_max = take ? y_in  : run_max_q;
    cap_ch  = take ? sel_q : run_ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= '0;
      max_val_q   <= '0;
      max_ch_q    <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      run_max_q   <= '0;
      run_ch_q    <= '0;
      run_empty_q <= 1'b1;
      for (int unsigned i = 0; i < 8; i++) bank_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            valid_q <= '0;
            if (mask != 8'h00) begin
              mask_q      <= mask;
              cont_q      <= continuous;
              sel_q       <= first_in;
              cnt_q       <= '0;
              busy_q      <= 1'b1;
              run_empty_q <= 1'b1;
              state_q     <= SCAN;
            end else begin
              done_q    <= 1'b1;
              max_val_q <= '0;
              max_ch_q  <= '0;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q != SETTLE_C) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            bank_q[sel_q]  <= y_in;
            valid_q[sel_q] <= 1'b1;
            cnt_q          <= '0;
            if (has_next) begin
              sel_q       <= next_ch;
              run_max_q   <= cap_max;
              run_ch_q    <= cap_ch;
              run_empty_q <= 1'b0;
            end else begin
              max_val_q <= cap_max;
              max_ch_q  <= cap_ch;
              done_q    <= 1'b1;
              if (cont_q) begin
                sel_q       <= first_q;
                run_empty_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign max_val = max_val_q;
  assign max_ch  = max_ch_q;
  assign rd_data = bank_q[rd_addr];

endmodule
